// File: rtl/serial_word_feeder.sv
// rtl/serial_word_feeder.sv - serializes a parallel word LSB-first into a downstream shift register, with optional preset pulse

module serial_word_feeder #(
  parameter int   WIDTH      = 4,
  parameter logic IDLE_LEVEL = 1'b0,
  localparam int  CW         = (WIDTH < 1) ? 1 : $clog2(WIDTH + 1)
) (
  input  logic             clockpulse,
  input  logic             clear,
  input  logic [WIDTH-1:0] dataIn,
  input  logic             loadPreset,
  input  logic [3:0]       presetIn,
  input  logic             dataValid,
  output logic             dataReady,
  output logic             serialOut,
  output logic             enablePreset,
  output logic [3:0]       presetOut,
  output logic             busy,
  output logic [CW-1:0]    bitCount,
  output logic             wordDone
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRESET = 2'd1,
    SHIFT  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ALL_BITS = CW'(WIDTH);

  state_t           state;
  // Bits still to be presented; bit 0 is always the next one to go out.
  logic [WIDTH-1:0] shift_q;

  // Handshake and busy are pure decodes of the state register, so they carry no input-to-output path.
  assign dataReady = (state == IDLE);
  assign busy      = (state == PRESET) || (state == SHIFT);

  // Single sequencer: accepts a word, optionally pulses preset, then walks the bits out one per clock.
  always_ff @(posedge clockpulse) begin
    if (clear) begin
      state        <= IDLE;
      shift_q      <= '0;
      serialOut    <= IDLE_LEVEL;
      enablePreset <= 1'b0;
      presetOut    <= 4'd0;
      bitCount     <= '0;
      wordDone     <= 1'b0;
    end else begin
      wordDone <= 1'b0;
      case (state)
        IDLE: begin
          bitCount <= '0;
          if (dataValid) begin
            if (loadPreset) begin
              // Hold the whole word; the preset cycle comes first.
              state        <= PRESET;
              shift_q      <= dataIn;
              enablePreset <= 1'b1;
              presetOut    <= presetIn;
              serialOut    <= IDLE_LEVEL;
            end else begin
              // Bit 0 goes out in the very next cycle.
              state     <= SHIFT;
              serialOut <= dataIn[0];
              shift_q   <= dataIn >> 1;
            end
          end
        end

        PRESET: begin
          // Preset pins drop back to zero as soon as the pulse cycle ends.
          state        <= SHIFT;
          enablePreset <= 1'b0;
          presetOut    <= 4'd0;
          serialOut    <= shift_q[0];
          shift_q      <= shift_q >> 1;
          bitCount     <= '0;
        end

        SHIFT: begin
          if (bitCount == LAST_BIT) begin
            state     <= DONE;
            wordDone  <= 1'b1;
            bitCount  <= ALL_BITS;
            serialOut <= IDLE_LEVEL;
          end else begin
            bitCount  <= bitCount + CW'(1);
            serialOut <= shift_q[0];
            shift_q   <= shift_q >> 1;
          end
        end

        DONE: begin
          state    <= IDLE;
          bitCount <= '0;
        end

        default: begin
          state     <= IDLE;
          serialOut <= IDLE_LEVEL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_word_feeder.sv
// tb/tb_serial_word_feeder.sv - directed self-checking bench for serial_word_feeder

module tb_serial_word_feeder;

  logic       clockpulse = 1'b0;
  logic       clear      = 1'b1;
  logic [3:0] dataIn     = 4'd0;
  logic       loadPreset = 1'b0;
  logic [3:0] presetIn   = 4'd0;
  logic       dataValid  = 1'b0;
  logic       dataReady;
  logic       serialOut;
  logic       enablePreset;
  logic [3:0] presetOut;
  logic       busy;
  logic [2:0] bitCount;
  logic       wordDone;

  int tests_run = 0;
  int tests_failed = 0;

  // Downstream 4-bit register: preset load, otherwise serial input enters at the top so LSB-first lands in out[3:0].
  logic [3:0] down_q = 4'd0;

  serial_word_feeder #(.WIDTH(4), .IDLE_LEVEL(1'b0)) dut (
    .clockpulse  (clockpulse),
    .clear       (clear),
    .dataIn      (dataIn),
    .loadPreset  (loadPreset),
    .presetIn    (presetIn),
    .dataValid   (dataValid),
    .dataReady   (dataReady),
    .serialOut   (serialOut),
    .enablePreset(enablePreset),
    .presetOut   (presetOut),
    .busy        (busy),
    .bitCount    (bitCount),
    .wordDone    (wordDone)
  );

  always #5 clockpulse = ~clockpulse;

  // Downstream shift register model.
  always_ff @(posedge clockpulse) begin
    if (enablePreset) down_q <= presetOut;
    else              down_q <= {serialOut, down_q[3:1]};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clockpulse);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".ready"}, dataReady, 1);
    check({tag, ".serial"}, serialOut, 0);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".enpre"}, enablePreset, 0);
    check({tag, ".preout"}, presetOut, 0);
    check({tag, ".bitcnt"}, bitCount, 0);
    check({tag, ".done"}, wordDone, 0);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!dataReady && n < 20) begin
      tick();
      n++;
    end
    check({tag, ".ready_timeout"}, dataReady, 1);
  endtask

  // Shift cycle k of word w: expected bit, count and handshake state.
  task automatic check_shift(input string tag, input logic [3:0] w, input int k);
    check($sformatf("%s.bit%0d", tag, k), serialOut, w[k]);
    check($sformatf("%s.cnt%0d", tag, k), bitCount, k);
    check($sformatf("%s.busy%0d", tag, k), busy, 1);
    check($sformatf("%s.rdy%0d", tag, k), dataReady, 0);
    check($sformatf("%s.enp%0d", tag, k), enablePreset, 0);
    check($sformatf("%s.pro%0d", tag, k), presetOut, 0);
    check($sformatf("%s.wd%0d", tag, k), wordDone, 0);
  endtask

  task automatic check_done(input string tag, input logic [3:0] model_exp);
    check({tag, ".wordDone"}, wordDone, 1);
    check({tag, ".cnt4"}, bitCount, 4);
    check({tag, ".serial_idle"}, serialOut, 0);
    check({tag, ".busy_done"}, busy, 0);
    check({tag, ".rdy_done"}, dataReady, 0);
    check({tag, ".downstream"}, down_q, model_exp);
  endtask

  // One full word transfer; noise scribbles on dataValid/dataIn while the block is busy.
  task automatic send(input string tag, input logic [3:0] w, input logic lp,
                      input logic [3:0] pv, input logic [3:0] model_exp, input bit noise);
    wait_ready(tag);
    dataIn = w; loadPreset = lp; presetIn = pv; dataValid = 1'b1;
    tick();
    dataValid = 1'b0;
    if (lp) begin
      check({tag, ".pre_en"}, enablePreset, 1);
      check({tag, ".pre_val"}, presetOut, pv);
      check({tag, ".pre_serial"}, serialOut, 0);
      check({tag, ".pre_busy"}, busy, 1);
      check({tag, ".pre_rdy"}, dataReady, 0);
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      if (noise) begin
        dataValid = $urandom_range(0, 1);
        dataIn    = 4'($urandom_range(0, 15));
        loadPreset = $urandom_range(0, 1);
      end
      check_shift(tag, w, k);
      tick();
    end
    if (noise) begin
      dataValid = 1'b1;
      dataIn    = ~w;
    end
    check_done(tag, model_exp);
    dataValid = 1'b0;
    loadPreset = 1'b0;
    tick();
    check({tag, ".ready_after"}, dataReady, 1);
    check({tag, ".done_cleared"}, wordDone, 0);
  endtask

  initial begin
    // 1. Reset then idle.
    clear = 1'b1;
    tick();
    tick();
    clear = 1'b0;
    check_idle("reset");
    for (int i = 0; i < 10; i++) begin
      tick();
      check_idle($sformatf("idle%0d", i));
    end

    // 2. Plain word.
    send("plain", 4'b1011, 1'b0, 4'b0000, 4'b1011, 1'b0);

    // 3. Preset then zeros: downstream register ends cleared.
    send("preset", 4'b0000, 1'b1, 4'b1111, 4'b0000, 1'b0);

    // 4. Back-to-back with dataValid held high.
    wait_ready("b2b");
    dataIn = 4'h5; loadPreset = 1'b0; dataValid = 1'b1;
    tick();
    dataIn = 4'hA;
    for (int k = 0; k < 4; k++) begin
      check_shift("b2b_a", 4'h5, k);
      tick();
    end
    check_done("b2b_a", 4'h5);
    tick();
    check("b2b.ready_at_6", dataReady, 1);
    tick();
    dataValid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check_shift("b2b_b", 4'hA, k);
      tick();
    end
    check_done("b2b_b", 4'hA);
    tick();

    // 5. Reset mid-word at bitCount=2, then a clean word.
    wait_ready("midrst");
    dataIn = 4'b1110; dataValid = 1'b1;
    tick();
    dataValid = 1'b0;
    tick();
    tick();
    check("midrst.cnt2", bitCount, 2);
    clear = 1'b1;
    dataValid = 1'b1;
    tick();
    clear = 1'b0;
    dataValid = 1'b0;
    check_idle("midrst.after");
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("midrst.nodone%0d", i), wordDone, 0);
      check($sformatf("midrst.stay_idle%0d", i), busy, 0);
    end
    send("midrst.new", 4'b0110, 1'b0, 4'b0000, 4'b0110, 1'b0);

    // 6. Inputs toggled while busy are ignored.
    send("noise", 4'b1001, 1'b0, 4'b0000, 4'b1001, 1'b1);
    send("noise_pre", 4'b0011, 1'b1, 4'b1010, 4'b0011, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
